// File: rtl/ram_ff_mp.sv
`default_nettype none
// ============================================================================
// ram_ff_mp : multi-port flip-flop RAM, lowest-port-wins writes, sequenced clear.
// Optional macro RAM_FF_MP_BYPASS_EN forwards same-cycle write data to reads.
// Revision : 1.0
// ============================================================================
module ram_ff_mp #(
    parameter int                   DATAWIDTH = 8,
    parameter int                   ADDRWIDTH = 3,
    parameter int                   NUM_WR    = 2,
    parameter int                   NUM_RD    = 2,
    parameter int                   RD_REG    = 1,
    parameter logic [DATAWIDTH-1:0] INIT_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WR-1:0]              en_w_n,
    input  logic [NUM_WR*ADDRWIDTH-1:0]    addr_w,
    input  logic [NUM_WR*DATAWIDTH-1:0]    data_w,
    input  logic [NUM_RD-1:0]              en_r_n,
    input  logic [NUM_RD*ADDRWIDTH-1:0]    addr_r,
    output logic [NUM_RD*DATAWIDTH-1:0]    data_r,
    output logic [NUM_RD-1:0]              rd_valid,
    input  logic                           clr_req,
    output logic                           busy
);

    localparam int DEPTH = 2**ADDRWIDTH;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDRWIDTH-1:0] r_cnt;
    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    logic                 w_busy;
    logic [DEPTH-1:0]     w_we;
    logic [DATAWIDTH-1:0] w_wdata [DEPTH];
    logic [DATAWIDTH-1:0] w_rdata [NUM_RD];

    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ports scanned high to low so the lowest-index enabled port has the last word.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            w_we[a]    = 1'b0;
            w_wdata[a] = INIT_VAL;
            if (w_busy) begin
                if (r_cnt == ADDRWIDTH'(a)) begin
                    w_we[a] = 1'b1;
                end
            end else begin
                for (int i = NUM_WR-1; i >= 0; i--) begin
                    if (!en_w_n[i] && (addr_w[i*ADDRWIDTH +: ADDRWIDTH] == ADDRWIDTH'(a))) begin
                        w_we[a]    = 1'b1;
                        w_wdata[a] = data_w[i*DATAWIDTH +: DATAWIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                r_mem[a] <= INIT_VAL;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (w_we[a]) begin
                    r_mem[a] <= w_wdata[a];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            w_rdata[j] = r_mem[addr_r[j*ADDRWIDTH +: ADDRWIDTH]];
`ifdef RAM_FF_MP_BYPASS_EN
            for (int i = NUM_WR-1; i >= 0; i--) begin
                if (!w_busy && !en_w_n[i] &&
                    (addr_w[i*ADDRWIDTH +: ADDRWIDTH] == addr_r[j*ADDRWIDTH +: ADDRWIDTH])) begin
                    w_rdata[j] = data_w[i*DATAWIDTH +: DATAWIDTH];
                end
            end
`endif
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DATAWIDTH-1:0] r_rdata [NUM_RD];
            logic [NUM_RD-1:0]    r_rd_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < NUM_RD; j++) begin
                        r_rdata[j] <= INIT_VAL;
                    end
                    r_rd_valid <= '0;
                end else begin
                    for (int j = 0; j < NUM_RD; j++) begin
                        if (!en_r_n[j]) begin
                            r_rdata[j] <= w_rdata[j];
                        end
                        r_rd_valid[j] <= ~en_r_n[j] & ~w_busy;
                    end
                end
            end

            for (genvar j = 0; j < NUM_RD; j++) begin : g_out
                assign data_r[j*DATAWIDTH +: DATAWIDTH] = r_rdata[j];
            end
            assign rd_valid = r_rd_valid;
        end else begin : g_rd_comb
            for (genvar j = 0; j < NUM_RD; j++) begin : g_out
                assign data_r[j*DATAWIDTH +: DATAWIDTH] = w_rdata[j];
                assign rd_valid[j] = ~en_r_n[j] & ~w_busy;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_ff_mp.sv
`default_nettype none
// ============================================================================
// tb_ram_ff_mp : directed vector bench for ram_ff_mp (2W/2R, registered read).
// Revision : 1.0
// ============================================================================
module tb_ram_ff_mp;

    localparam logic [7:0] C_INIT = 8'h5A;
`ifdef RAM_FF_MP_BYPASS_EN
    localparam logic [7:0] C_RDW  = 8'h22;
    localparam logic [7:0] C_BYP3 = 8'h33;
`else
    localparam logic [7:0] C_RDW  = 8'h11;
    localparam logic [7:0] C_BYP3 = 8'h5A;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  en_w_n = 2'b11;
    logic [5:0]  addr_w = '0;
    logic [15:0] data_w = '0;
    logic [1:0]  en_r_n = 2'b11;
    logic [5:0]  addr_r = '0;
    logic [15:0] data_r;
    logic [1:0]  rd_valid;
    logic        clr_req = 1'b0;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ram_ff_mp #(
        .DATAWIDTH (8),
        .ADDRWIDTH (3),
        .NUM_WR    (2),
        .NUM_RD    (2),
        .RD_REG    (1),
        .INIT_VAL  (C_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_w_n   (en_w_n),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .en_r_n   (en_r_n),
        .addr_r   (addr_r),
        .data_r   (data_r),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ew;
        logic [5:0]  aw;
        logic [15:0] dw;
        logic [1:0]  er;
        logic [5:0]  ar;
        logic [15:0] exp_d;
        logic [1:0]  exp_v;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ew, input logic [5:0] aw, input logic [15:0] dw,
                         input logic [1:0] er, input logic [5:0] ar, input logic cr);
        @(negedge clk);
        en_w_n  = ew;
        addr_w  = aw;
        data_w  = dw;
        en_r_n  = er;
        addr_r  = ar;
        clr_req = cr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ff();
        for (int a = 0; a < 8; a += 2) begin
            logic [2:0] a3;
            a3 = 3'(a);
            drive(2'b00, {a3 + 3'd1, a3}, 16'hFFFF, 2'b11, 6'd0, 1'b0);
            step();
        end
    endtask

    task automatic read_all(input string name);
        for (int a = 0; a < 8; a += 2) begin
            logic [2:0] a3;
            a3 = 3'(a);
            drive(2'b11, 6'd0, 16'd0, 2'b00, {a3 + 3'd1, a3}, 1'b0);
            step();
            chk({name, "_data"}, 32'(data_r), 32'({C_INIT, C_INIT}));
            chk({name, "_valid"}, 32'(rd_valid), 32'd3);
        end
    endtask

    // Clear sweep with a dropped write and an ignored clr_req while busy.
    task automatic sweep(output int nb);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)
                drive(2'b11, 6'd0, 16'd0, 2'b11, 6'd0, 1'b1);
            else if (i == 2)
                drive(2'b10, {3'd0, 3'd4}, 16'h0077, 2'b10, {3'd0, 3'd4}, 1'b0);
            else if (i == 5)
                drive(2'b11, 6'd0, 16'd0, 2'b11, 6'd0, 1'b1);
            else
                drive(2'b11, 6'd0, 16'd0, 2'b11, 6'd0, 1'b0);
            step();
            if (busy) nb++;
            if (i == 2) chk("busy_rd_valid", 32'(rd_valid), 32'd0);
        end
    endtask

    initial begin
        int nb;

        vecs[0]  = '{2'b01, {3'd5, 3'd0}, {8'h3C, 8'h00}, 2'b11, 6'd0,          {C_INIT, C_INIT}, 2'b00};
        vecs[1]  = '{2'b11, 6'd0,         16'h0000,       2'b10, {3'd0, 3'd5},  {C_INIT, 8'h3C},  2'b01};
        vecs[2]  = '{2'b11, 6'd0,         16'h0000,       2'b11, 6'd0,          {C_INIT, 8'h3C},  2'b00};
        vecs[3]  = '{2'b00, {3'd2, 3'd2}, {8'h55, 8'hAA}, 2'b01, {3'd5, 3'd0},  {8'h3C, 8'h3C},   2'b10};
        vecs[4]  = '{2'b11, 6'd0,         16'h0000,       2'b00, {3'd2, 3'd2},  {8'hAA, 8'hAA},   2'b11};
        vecs[5]  = '{2'b00, {3'd1, 3'd0}, {8'h02, 8'h01}, 2'b11, 6'd0,          {8'hAA, 8'hAA},   2'b00};
        vecs[6]  = '{2'b11, 6'd0,         16'h0000,       2'b00, {3'd0, 3'd1},  {8'h01, 8'h02},   2'b11};
        vecs[7]  = '{2'b10, {3'd0, 3'd7}, {8'h00, 8'h11}, 2'b11, 6'd0,          {8'h01, 8'h02},   2'b00};
        vecs[8]  = '{2'b01, {3'd7, 3'd0}, {8'h22, 8'h00}, 2'b10, {3'd0, 3'd7},  {8'h01, C_RDW},   2'b01};
        vecs[9]  = '{2'b11, 6'd0,         16'h0000,       2'b01, {3'd7, 3'd0},  {8'h22, C_RDW},   2'b10};
        vecs[10] = '{2'b00, {3'd3, 3'd3}, {8'h44, 8'h33}, 2'b10, {3'd0, 3'd3},  {8'h22, C_BYP3},  2'b01};
        vecs[11] = '{2'b11, 6'd0,         16'h0000,       2'b01, {3'd3, 3'd0},  {8'h33, C_BYP3},  2'b10};

        #12;
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data",  32'(data_r),   32'({C_INIT, C_INIT}));
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle.
        drive(2'b10, {3'd0, 3'd1}, 16'h00FF, 2'b11, 6'd0, 1'b0);
        step();
        drive(2'b11, 6'd0, 16'd0, 2'b10, {3'd0, 3'd1}, 1'b0);
        step();
        chk("pre_data",  32'(data_r),   32'({C_INIT, 8'hFF}));
        chk("pre_valid", 32'(rd_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_data",  32'(data_r),   32'({C_INIT, C_INIT}));
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_busy",  32'(busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 6'd0, 16'd0, 2'b10, {3'd0, 3'd1}, 1'b0);
        step();
        chk("async_mem", 32'(data_r), 32'({C_INIT, C_INIT}));

        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].ew, vecs[k].aw, vecs[k].dw, vecs[k].er, vecs[k].ar, 1'b0);
            step();
            chk($sformatf("vec%0d_data", k),  32'(data_r),   32'(vecs[k].exp_d));
            chk($sformatf("vec%0d_valid", k), 32'(rd_valid), 32'(vecs[k].exp_v));
        end

        fill_ff();
        sweep(nb);
        chk("sweep_busy_cycles", 32'(nb),   32'd8);
        chk("sweep_busy_end",    32'(busy), 32'd0);
        read_all("after_clear");

        // Abort a sweep with reset on its 4th busy cycle.
        fill_ff();
        nb = 0;
        for (int i = 0; i < 20 && nb < 4; i++) begin
            drive(2'b11, 6'd0, 16'd0, 2'b11, 6'd0, (i == 0));
            step();
            if (busy) nb++;
        end
        chk("midclr_reached", 32'(nb), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midclr_busy",  32'(busy),     32'd0);
        chk("midclr_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_all("midclr_mem");

        fill_ff();
        sweep(nb);
        chk("resweep_busy_cycles", 32'(nb), 32'd8);
        read_all("after_resweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_ff_mp.md
# ram_ff_mp

Parametrised multi-port flip-flop RAM. It is the successor to the fixed 2W/2R FF RAM: any number of write and read ports, selectable registered or combinational read, deterministic write-collision priority, and a sequenced background clear with a busy flag. It sits in the datapath as small register-file or scratch storage. It is cleared by reset or by a software-triggered sweep.

## Interface
Parameters:
- DATAWIDTH, 8, word width in bits
- ADDRWIDTH, 3, address width; DEPTH = 2**ADDRWIDTH words, full address space used
- NUM_WR, 2, number of write ports (≥1)
- NUM_RD, 2, number of read ports (≥1)
- RD_REG, 1, 1 = registered read (1-cycle latency), 0 = combinational read
- INIT_VAL, 0, value loaded into every word by reset and by clear

Ports (port i occupies slice [i*W +: W] of each flattened bus):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en_w_n  in  NUM_WR  write enables, active-low
- addr_w  in  NUM_WR*ADDRWIDTH  write addresses
- data_w  in  NUM_WR*DATAWIDTH  write data
- en_r_n  in  NUM_RD  read enables, active-low
- addr_r  in  NUM_RD*ADDRWIDTH  read addresses
- data_r  out  NUM_RD*DATAWIDTH  read data
- rd_valid  out  NUM_RD  read data valid, per port
- clr_req  in  1  request a full-array clear, sampled on clk
- busy  out  1  clear sweep in progress

## Operation
- Reset (rst_n low, asynchronous) has the following effect:
  - All words become INIT_VAL.
  - The FSM goes to IDLE.
  - data_r becomes INIT_VAL on all ports (RD_REG=1).
  - rd_valid becomes 0 and busy becomes 0.
- Writes: in IDLE, each port with en_w_n[i]=0 writes data_w[i] to addr_w[i] at the clock edge.
- Collision rule: when several enabled write ports target the same address, the lowest-index port wins. Writes to distinct addresses all commit.
- Reads with RD_REG=1:
  - On an edge where en_r_n[j]=0, data_r[j] ← mem[addr_r[j]] and rd_valid[j] ← 1.
  - When en_r_n[j]=1, data_r[j] holds its value and rd_valid[j] ← 0.
- Reads with RD_REG=0: data_r[j] = mem[addr_r[j]] continuously, and rd_valid[j] = ~en_r_n[j] & ~busy.
- Read-during-write to the same address:
  - Without the bypass feature, a registered read returns the pre-write contents.
  - A combinational read shows the new value after the edge.
- FSM states:
  - IDLE: clr_req=1 at an edge moves to CLEAR and resets the counter cnt to 0.
  - CLEAR: each edge writes INIT_VAL to mem[cnt] and increments cnt. The edge where cnt = DEPTH-1 returns to IDLE; the cnt wrap is not observable.
- busy = (state == CLEAR).
- While busy:
  - All writes are dropped.
  - clr_req is ignored.
  - Reads still access the array (partially cleared contents), but rd_valid is forced to 0.
- Reset asserted mid-clear aborts the sweep, and the whole array becomes INIT_VAL immediately.

## Timing
- Registered read latency is 1 cycle: address and enable applied before edge N give data_r and rd_valid after edge N.
- Clear sequencing, with clr_req sampled at edge N:
  - busy is high in cycles N+1 … N+DEPTH.
  - Words 0…DEPTH-1 are written at edges N+1…N+DEPTH.
  - Writes are accepted again from edge N+DEPTH+1.
- A write applied at the same edge as the clr_req sample commits, because the FSM is still in IDLE.
- There is no back-pressure. Users must watch busy.

## Configuration
- RAM_FF_MP_BYPASS_EN defined:
  - A read whose address matches an enabled write port in the same cycle returns that write's data, taken from the winning (lowest-index) port.
  - For RD_REG=1 the data is registered at that edge. For RD_REG=0 it is driven combinationally.
  - Bypass is inactive while busy.
- RAM_FF_MP_BYPASS_EN undefined: there is no forwarding, and reads always return the stored array contents as described above.

## Test plan
- Reset: INIT_VAL=8'h5A, pulse rst_n low mid-cycle → every address reads 8'h5A, rd_valid=0, busy=0, all asynchronously.
- Basic write/read: write 8'h3C to addr 5 via port 1, then read addr 5 on port 0 with RD_REG=1 → data_r[0]=8'h3C one cycle later, rd_valid[0]=1 for that one cycle.
- Collision: port 0 writes 8'hAA and port 1 writes 8'h55, both to addr 2 in the same cycle → addr 2 reads 8'hAA.
- Read-during-write at addr 7 (old value 8'h11, new value 8'h22), RD_REG=1:
  - Macro undefined → returns 8'h11.
  - RAM_FF_MP_BYPASS_EN defined → returns 8'h22.
- Clear sweep with ADDRWIDTH=3: array filled with 8'hFF, pulse clr_req:
  - busy is high for exactly 8 cycles.
  - A write issued during busy is dropped.
  - Afterwards all words read INIT_VAL.
- Reset mid-clear: assert rst_n low on the 4th busy cycle → busy=0 immediately, all words INIT_VAL, and a clr_req after reset runs a full 8-cycle sweep.
